// File: rtl/regfile_2w2r_if.sv
// Register file bus: two read address/data pairs and two write lanes.
// The master side (decode/writeback) drives addresses and write lanes.
// The slave side (the register file) returns the read data.
interface regfile_2w2r_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] ReadRegister1;
    logic [ADDR_WIDTH-1:0] ReadRegister2;
    logic [DATA_WIDTH-1:0] ReadData1;
    logic [DATA_WIDTH-1:0] ReadData2;
    logic [ADDR_WIDTH-1:0] WriteRegisterA;
    logic [DATA_WIDTH-1:0] WriteDataA;
    logic                  RegWriteA;
    logic [ADDR_WIDTH-1:0] WriteRegisterB;
    logic [DATA_WIDTH-1:0] WriteDataB;
    logic                  RegWriteB;

    modport master (
        output ReadRegister1, ReadRegister2,
        output WriteRegisterA, WriteDataA, RegWriteA,
        output WriteRegisterB, WriteDataB, RegWriteB,
        input  ReadData1, ReadData2
    );

    modport slave (
        input  ReadRegister1, ReadRegister2,
        input  WriteRegisterA, WriteDataA, RegWriteA,
        input  WriteRegisterB, WriteDataB, RegWriteB,
        output ReadData1, ReadData2
    );
endinterface

// File: rtl/regfile_2w2r.sv
// Two-write, two-read register file for the CPU datapath.
// Reads are combinational; writes commit on the rising clock edge.
// Lane B has priority over lane A when both target the same register.
// ZERO_REG hardwires register 0 to zero; BYPASS forwards same-cycle
// write data to a matching read port.
module regfile_2w2r #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 0
) (
    input  logic           Clk,
    input  logic           Reset_n,
    regfile_2w2r_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  we_a;
    logic                  we_b;
    logic [DATA_WIDTH-1:0] rd1;
    logic [DATA_WIDTH-1:0] rd2;

    // Write enables with register-0 writes dropped when it is hardwired.
    always_comb begin
        we_a = bus.RegWriteA;
        we_b = bus.RegWriteB;
        if (ZERO_REG != 0) begin
            if (bus.WriteRegisterA == '0) we_a = 1'b0;
            if (bus.WriteRegisterB == '0) we_b = 1'b0;
        end
    end

    // Storage: synchronous clear, otherwise lane A then lane B so B wins a collision.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (we_a) mem[bus.WriteRegisterA] <= bus.WriteDataA;
            if (we_b) mem[bus.WriteRegisterB] <= bus.WriteDataB;
        end
    end

    // Read selection: zero register, then lane B bypass, lane A bypass, stored value.
    function automatic logic [DATA_WIDTH-1:0] read_sel(input logic [ADDR_WIDTH-1:0] addr);
        logic [DATA_WIDTH-1:0] val;
        val = mem[addr];
        if (BYPASS != 0 && Reset_n) begin
            if (bus.RegWriteB && bus.WriteRegisterB == addr)
                val = bus.WriteDataB;
            else if (bus.RegWriteA && bus.WriteRegisterA == addr)
                val = bus.WriteDataA;
        end
        if (ZERO_REG != 0 && addr == '0) val = '0;
        return val;
    endfunction

    // Read port 1.
    always_comb begin
        rd1 = read_sel(bus.ReadRegister1);
    end

    // Read port 2.
    always_comb begin
        rd2 = read_sel(bus.ReadRegister2);
    end

    assign bus.ReadData1 = rd1;
    assign bus.ReadData2 = rd2;
endmodule

// File: tb/tb_regfile_2w2r.sv
// Bench for regfile_2w2r: three configurations driven by one stimulus stream.
//   z: ZERO_REG=1 BYPASS=0   b: ZERO_REG=1 BYPASS=1   n: ZERO_REG=0 BYPASS=0
// Expected read values come from a bench-side memory model and flow
// through a scoreboard queue.
module tb_regfile_2w2r;
    logic        clk;
    logic        rst_n;
    logic [4:0]  rr1, rr2, wr_a, wr_b;
    logic [31:0] wd_a, wd_b;
    logic        we_a, we_b;

    logic [31:0] mem_m [32];
    logic [31:0] z0_m;

    logic [31:0] sb_q [$];
    string       tag_q [$];

    int n_checks = 0;
    int n_pass   = 0;

    regfile_2w2r_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) if_z ();
    regfile_2w2r_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) if_b ();
    regfile_2w2r_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) if_n ();

    assign if_z.ReadRegister1 = rr1;  assign if_z.ReadRegister2 = rr2;
    assign if_z.WriteRegisterA = wr_a; assign if_z.WriteDataA = wd_a; assign if_z.RegWriteA = we_a;
    assign if_z.WriteRegisterB = wr_b; assign if_z.WriteDataB = wd_b; assign if_z.RegWriteB = we_b;
    assign if_b.ReadRegister1 = rr1;  assign if_b.ReadRegister2 = rr2;
    assign if_b.WriteRegisterA = wr_a; assign if_b.WriteDataA = wd_a; assign if_b.RegWriteA = we_a;
    assign if_b.WriteRegisterB = wr_b; assign if_b.WriteDataB = wd_b; assign if_b.RegWriteB = we_b;
    assign if_n.ReadRegister1 = rr1;  assign if_n.ReadRegister2 = rr2;
    assign if_n.WriteRegisterA = wr_a; assign if_n.WriteDataA = wd_a; assign if_n.RegWriteA = we_a;
    assign if_n.WriteRegisterB = wr_b; assign if_n.WriteDataB = wd_b; assign if_n.RegWriteB = we_b;

    regfile_2w2r #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1), .BYPASS(0))
        dut_z (.Clk(clk), .Reset_n(rst_n), .bus(if_z));
    regfile_2w2r #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1), .BYPASS(1))
        dut_b (.Clk(clk), .Reset_n(rst_n), .bus(if_b));
    regfile_2w2r #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(0), .BYPASS(0))
        dut_n (.Clk(clk), .Reset_n(rst_n), .bus(if_n));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] exp_z(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : mem_m[a];
    endfunction

    function automatic logic [31:0] exp_n(input logic [4:0] a);
        return (a == 5'd0) ? z0_m : mem_m[a];
    endfunction

    function automatic logic [31:0] exp_b(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (rst_n && we_b && wr_b == a) return wd_b;
        if (rst_n && we_a && wr_a == a) return wd_a;
        return mem_m[a];
    endfunction

    // Drive both read addresses, queue expectations, then compare.
    task automatic rd(input int a1, input int a2);
        logic [31:0] obs [6];
        rr1 = a1[4:0];
        rr2 = a2[4:0];
        sb_q.push_back(exp_z(rr1)); tag_q.push_back($sformatf("z.rd1[%0d]", a1));
        sb_q.push_back(exp_z(rr2)); tag_q.push_back($sformatf("z.rd2[%0d]", a2));
        sb_q.push_back(exp_b(rr1)); tag_q.push_back($sformatf("b.rd1[%0d]", a1));
        sb_q.push_back(exp_b(rr2)); tag_q.push_back($sformatf("b.rd2[%0d]", a2));
        sb_q.push_back(exp_n(rr1)); tag_q.push_back($sformatf("n.rd1[%0d]", a1));
        sb_q.push_back(exp_n(rr2)); tag_q.push_back($sformatf("n.rd2[%0d]", a2));
        #1;
        obs[0] = if_z.ReadData1; obs[1] = if_z.ReadData2;
        obs[2] = if_b.ReadData1; obs[3] = if_b.ReadData2;
        obs[4] = if_n.ReadData1; obs[5] = if_n.ReadData2;
        for (int k = 0; k < 6; k++) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                check(tag_q.pop_front(), obs[k], sb_q.pop_front());
            end
        end
    endtask

    // Apply the current inputs to the model and advance one clock edge.
    task automatic tick();
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) mem_m[i] = 32'd0;
            z0_m = 32'd0;
        end else begin
            if (we_a) begin
                if (wr_a == 5'd0) z0_m = wd_a; else mem_m[wr_a] = wd_a;
            end
            if (we_b) begin
                if (wr_b == 5'd0) z0_m = wd_b; else mem_m[wr_b] = wd_b;
            end
        end
        @(posedge clk);
        #1;
        we_a = 1'b0;
        we_b = 1'b0;
    endtask

    task automatic wr_lane_a(input int a, input logic [31:0] d);
        wr_a = a[4:0]; wd_a = d; we_a = 1'b1;
    endtask

    task automatic wr_lane_b(input int a, input logic [31:0] d);
        wr_b = a[4:0]; wd_b = d; we_b = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        rr1 = '0; rr2 = '0;
        wr_a = '0; wr_b = '0; wd_a = '0; wd_b = '0;
        we_a = 1'b0; we_b = 1'b0;
        for (int i = 0; i < 32; i++) mem_m[i] = 32'd0;
        z0_m = 32'd0;

        // Reset, then every address reads zero on both ports.
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) rd(i, i);

        // Single write through lane A.
        wr_lane_a(2, 32'd42);
        tick();
        rd(2, 2);

        // Disabled write lanes hold the register regardless of data/address.
        wr_lane_a(2, 32'd15);
        tick();
        wr_a = 5'd2; wd_a = 32'd16; we_a = 1'b0;
        wr_b = 5'd2; wd_b = 32'd17; we_b = 1'b0;
        tick();
        rd(2, 2);

        // Decoder sweep alternating lanes.
        for (int i = 1; i < 32; i++) begin
            if (i % 2 == 1) wr_lane_a(i, 32'(i + 100));
            else            wr_lane_b(i, 32'(i + 100));
            tick();
        end
        for (int i = 0; i < 32; i++) rd(i, 31 - i);

        // Dual write to distinct registers, then a same-address collision.
        wr_lane_a(5, 32'd7);
        wr_lane_b(9, 32'd8);
        tick();
        rd(5, 9);
        wr_lane_a(5, 32'd11);
        wr_lane_b(5, 32'd22);
        rd(5, 5);
        tick();
        rd(5, 5);

        // Both lanes write register 0; bypass must not leak into reads of r0.
        wr_lane_a(0, 32'd15);
        wr_lane_b(0, 32'd15);
        rd(0, 0);
        tick();
        rd(0, 0);

        // Bypass of lane A data before the edge.
        wr_lane_a(3, 32'd10);
        tick();
        wr_lane_a(3, 32'd20);
        rd(3, 4);
        tick();
        rd(3, 3);

        // Reset during a write: no bypass, no commit, everything cleared.
        wr_lane_a(3, 32'd10);
        tick();
        wr_lane_a(3, 32'd20);
        wr_lane_b(7, 32'd33);
        rst_n = 1'b0;
        rd(3, 7);
        tick();
        rd(3, 7);
        rd(0, 31);
        rst_n = 1'b1;
        wr_lane_a(7, 32'd5);
        tick();
        rd(7, 3);

        // Randomised traffic with frequent collisions on low addresses.
        for (int n = 0; n < 60; n++) begin
            we_a = 1'($urandom_range(0, 1));
            we_b = 1'($urandom_range(0, 1));
            wr_a = 5'($urandom_range(0, 7));
            wr_b = 5'($urandom_range(0, 7));
            wd_a = $urandom;
            wd_b = $urandom;
            rd(int'(wr_a), $urandom_range(0, 7));
            tick();
            rd($urandom_range(0, 7), $urandom_range(0, 31));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
